// File: rtl/wishbone_master_if.sv
// Core request/response channel plus Wishbone classic bus signals for
// wishbone_master. The master modport is the view seen by the master itself.
// The slave modport is the view seen by the core and by the bus device.
interface wishbone_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  // core side
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  req_we_i;
  logic                  resp_valid_o;
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_err_o;
  // bus side
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic                  sel_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  ack_i;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, data_i, ack_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           cyc_o, stb_o, we_o, sel_o, addr_o, data_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_we_i, data_i, ack_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           cyc_o, stb_o, we_o, sel_o, addr_o, data_o
  );
endinterface

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone classic master.
// It accepts one core load/store and runs one bus cycle. It then returns a
// one-cycle response. A missing ack becomes an error after TIMEOUT_CYCLES bus
// cycles, or never if TIMEOUT_CYCLES is 0.
module wishbone_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  wishbone_master_if.master bus
);
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value in the last bus cycle before a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             to_hit;

  // The counter starts at 0 in the first bus cycle. The timeout therefore
  // fires after exactly TIMEOUT_CYCLES cycles with strobe high.
  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // Ready is independent of req_valid, so the core may wait on it combinationally.
  assign bus.req_ready_o = (state == IDLE) && !rst_i;

  // Request FSM with all bus and response outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.cyc_o        <= 1'b0;
      bus.stb_o        <= 1'b0;
      bus.we_o         <= 1'b0;
      bus.sel_o        <= 1'b0;
      bus.addr_o       <= '0;
      bus.data_o       <= '0;
      bus.resp_valid_o <= 1'b0;
      bus.resp_err_o   <= 1'b0;
      bus.resp_rdata_o <= '0;
    end else begin
      bus.resp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.addr_o <= bus.req_addr_i;
            bus.data_o <= bus.req_wdata_i;
            bus.we_o   <= bus.req_we_i;
            bus.cyc_o  <= 1'b1;
            bus.stb_o  <= 1'b1;
            bus.sel_o  <= 1'b1;
            cnt        <= '0;
            state      <= BUS;
          end
        end
        BUS: begin
          if (bus.ack_i) begin
            // Ack beats a simultaneous timeout.
            bus.resp_rdata_o <= bus.we_o ? '0 : bus.data_i;
            bus.resp_err_o   <= 1'b0;
            bus.resp_valid_o <= 1'b1;
            bus.cyc_o        <= 1'b0;
            bus.stb_o        <= 1'b0;
            bus.sel_o        <= 1'b0;
            bus.we_o         <= 1'b0;
            state            <= RESP;
          end else if (to_hit) begin
            bus.resp_rdata_o <= '0;
            bus.resp_err_o   <= 1'b1;
            bus.resp_valid_o <= 1'b1;
            bus.cyc_o        <= 1'b0;
            bus.stb_o        <= 1'b0;
            bus.sel_o        <= 1'b0;
            bus.we_o         <= 1'b0;
            state            <= RESP;
          end else if (cnt != '1) begin
            // Saturates so that a disabled timeout can never wrap into a false hit.
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wishbone_master.sv
// Randomized self-checking bench for wishbone_master.
// Each transaction has expected latency, error, data, strobe and ack counts.
// These are derived from the slave's ack delay and the timeout rule.
module tb_wishbone_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wishbone_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slave model: the ack comes sl_d cycles after strobe rises; stray forces ack.
  int unsigned sl_d     = 1;
  bit          sl_noack = 1'b0;
  bit          stray    = 1'b0;
  logic [31:0] sl_data  = '0;
  int unsigned sl_n     = 0;

  always @(posedge clk) sl_n <= (bus.cyc_o && bus.stb_o) ? sl_n + 1 : 0;
  assign bus.ack_i  = stray || (bus.cyc_o && bus.stb_o && !sl_noack && sl_n == sl_d);
  assign bus.data_i = sl_data;

  // Monitor, sampling at the falling edge.
  int          cyc_n = 0, resp_tot = 0, stb_tot = 0, ack_tot = 0, bad_tot = 0, resp_cyc = 0;
  int          acc_q[$];
  logic [31:0] r_data = '0;
  logic        r_err  = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (bus.req_valid_i && bus.req_ready_o) acc_q.push_back(cyc_n);
    if (bus.resp_valid_o) begin
      resp_tot <= resp_tot + 1;
      resp_cyc <= cyc_n;
      r_data   <= bus.resp_rdata_o;
      r_err    <= bus.resp_err_o;
    end
    if (bus.stb_o) begin
      stb_tot <= stb_tot + 1;
      if (!bus.cyc_o || !bus.sel_o || bus.addr_o !== exp_addr ||
          bus.data_o !== exp_wdata || bus.we_o !== exp_we)
        bad_tot <= bad_tot + 1;
    end
    if (bus.stb_o && bus.ack_i) ack_tot <= ack_tot + 1;
  end

  // Runs one request and checks its response against the timing rules.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int unsigned d, input bit noack);
    int s_acc, s_resp, s_stb, s_ack, s_bad, a_cyc, exp_lat;
    bit exp_err;
    exp_err = noack || (TO != 0 && d >= TO);
    exp_lat = exp_err ? TO + 1 : int'(d) + 2;
    @(posedge clk); #1;
    exp_addr = addr; exp_wdata = wdata; exp_we = we;
    sl_d = d; sl_noack = noack; sl_data = rdata;
    s_acc = acc_q.size(); s_resp = resp_tot; s_stb = stb_tot; s_ack = ack_tot; s_bad = bad_tot;
    bus.req_valid_i = 1'b1; bus.req_addr_i = addr; bus.req_wdata_i = wdata; bus.req_we_i = we;
    for (int i = 0; i < 20 && acc_q.size() == s_acc; i++) @(posedge clk);
    #1;
    // Scramble the request fields so the bus-hold check catches any late sampling.
    bus.req_valid_i = 1'b0; bus.req_addr_i = $urandom; bus.req_wdata_i = $urandom; bus.req_we_i = ~we;
    if (acc_q.size() == s_acc) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    a_cyc = acc_q[s_acc];
    for (int i = 0; i < 80 && resp_tot == s_resp; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("resp_count", resp_tot - s_resp, 1);
    chk("latency", resp_cyc - a_cyc, exp_lat);
    chk("resp_err", r_err, exp_err);
    chk("resp_rdata", r_data, (exp_err || we) ? 32'h0 : rdata);
    chk("rdata_hold", bus.resp_rdata_o, r_data);
    chk("stb_cycles", stb_tot - s_stb, exp_err ? TO : int'(d) + 1);
    chk("ack_count", ack_tot - s_ack, exp_err ? 0 : 1);
    chk("bus_hold", bad_tot - s_bad, 0);
    chk("ready_idle", bus.req_ready_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_acc, s_resp, s_stb, s_ack, s_bad;
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_we_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_ctl", {bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o}, 0);
    chk("rst_resp", {bus.resp_valid_o, bus.resp_err_o}, 0);
    chk("rst_addr_data", {bus.addr_o, bus.data_o}, 0);
    chk("rst_rdata", bus.resp_rdata_o, 0);
    chk("rst_ready_low", bus.req_ready_o, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.req_ready_o, 1);

    // Directed cases.
    txn(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    txn(1'b1, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b0);
    txn(1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 0, 1'b1);
    txn(1'b0, 32'h0000_0084, 32'h0, 32'h0BAD_CAFE, TO - 1, 1'b0);
    txn(1'b0, 32'h0000_0088, 32'h0, 32'h1357_9BDF, 0, 1'b0);

    // Random cases; delays past TO-1 end in a timeout.
    for (int k = 0; k < 12; k++)
      txn(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 20),
          ($urandom_range(0, 7) == 0));

    // Reset while the bus cycle is waiting for an ack.
    @(posedge clk); #1;
    exp_addr = 32'hA000_0000; exp_wdata = 32'h5555_AAAA; exp_we = 1'b1;
    sl_noack = 1'b1;
    s_acc = acc_q.size();
    bus.req_valid_i = 1'b1; bus.req_addr_i = exp_addr; bus.req_wdata_i = exp_wdata; bus.req_we_i = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() == s_acc; i++) @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    chk("rst_mid_accept", acc_q.size() - s_acc, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_busy", bus.stb_o, 1);
    rst = 1'b1;
    s_resp = resp_tot;
    @(posedge clk); #1;
    chk("rst_mid_cyc_stb", {bus.cyc_o, bus.stb_o}, 0);
    chk("rst_mid_ready_low", bus.req_ready_o, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", bus.req_ready_o, 1);
    repeat (25) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", resp_tot - s_resp, 0);
    sl_noack = 1'b0;

    // Stray ack while idle.
    s_resp = resp_tot;
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stray = 1'b0;
    chk("stray_no_resp", resp_tot - s_resp, 0);
    chk("stray_no_cyc", bus.cyc_o, 0);
    chk("stray_ready", bus.req_ready_o, 1);

    // Back-to-back loads with valid held high and a stray ack in the first accept cycle.
    @(posedge clk); #1;
    exp_addr = $urandom; exp_wdata = $urandom; exp_we = 1'b0;
    sl_d = 1; sl_data = $urandom;
    s_acc = acc_q.size(); s_resp = resp_tot; s_stb = stb_tot; s_ack = ack_tot; s_bad = bad_tot;
    bus.req_valid_i = 1'b1; bus.req_addr_i = exp_addr; bus.req_wdata_i = exp_wdata; bus.req_we_i = 1'b0;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    for (int i = 0; i < 40 && acc_q.size() - s_acc < 5; i++) @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    chk("b2b_accepts", acc_q.size() - s_acc, 5);
    for (int i = 0; i < 40 && resp_tot - s_resp < 5; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 1; k < 5 && s_acc + k < acc_q.size(); k++)
      chk($sformatf("b2b_gap%0d", k), acc_q[s_acc + k] - acc_q[s_acc + k - 1], 4);
    chk("b2b_resps", resp_tot - s_resp, 5);
    chk("b2b_stb", stb_tot - s_stb, 10);
    chk("b2b_acks", ack_tot - s_ack, 5);
    chk("b2b_hold", bad_tot - s_bad, 0);
    chk("b2b_rdata", bus.resp_rdata_o, sl_data);
    chk("b2b_err", bus.resp_err_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
